// File: rtl/imm_pkg.sv
// Shared definitions for immediate decode: instruction-format encodings and the
// major opcodes that select them.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: f = FMT_I;
            OP_STORE:                           f = FMT_S;
            OP_BRANCH:                          f = FMT_B;
            OP_LUI, OP_AUIPC:                   f = FMT_U;
            OP_JAL:                             f = FMT_J;
            default:                            f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: classifies the opcode and assembles the
// XLEN-wide immediate for that format.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int LEGACY_ZEXT = 0
) (
    input  logic [31:0]     ins,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);

    logic [11:0] i_field;
    logic [11:0] s_field;
    logic [12:0] b_field;
    logic [31:0] u_field;
    logic [20:0] j_field;

    assign i_field = ins[31:20];
    assign s_field = {ins[31:25], ins[11:7]};
    assign b_field = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign u_field = {ins[31:12], 12'b0};
    assign j_field = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // Legacy mode mirrors the old single-cycle decoder: I/S/B zero-extended, B unshifted.
    always_comb begin
        fmt = opcode_fmt(ins[6:0]);
        imm = '0;
        case (fmt)
            FMT_I: imm = (LEGACY_ZEXT != 0) ? XLEN'(i_field) : XLEN'($signed(i_field));
            FMT_S: imm = (LEGACY_ZEXT != 0) ? XLEN'(s_field) : XLEN'($signed(s_field));
            FMT_B: imm = (LEGACY_ZEXT != 0) ? XLEN'(b_field[12:1]) : XLEN'($signed(b_field));
            FMT_U: imm = XLEN'($signed(u_field));
            FMT_J: imm = XLEN'($signed(j_field));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-then-buffer stage: immediates are extracted on entry and held in a
// small FIFO of {imm, fmt} entries with valid/ready handshakes on both sides.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH       = 2,
    parameter int LEGACY_ZEXT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              ins,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          imm,
    output logic [2:0]               fmt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;

    imm_extract #(
        .XLEN        (XLEN),
        .LEGACY_ZEXT (LEGACY_ZEXT)
    ) u_extract (
        .ins (ins),
        .imm (dec_imm),
        .fmt (dec_fmt)
    );

    logic [XLEN-1:0] imm_mem [DEPTH];
    fmt_e            fmt_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic            push;
    logic            pop;

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointers are PTR_W bits wide, so with a power-of-two DEPTH they wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_mem[wr_ptr] <= dec_imm;
            fmt_mem[wr_ptr] <= dec_fmt;
        end
    end

    // Storage is never reset, so the head is masked whenever the buffer is empty.
    assign imm = out_valid ? imm_mem[rd_ptr] : '0;
    assign fmt = out_valid ? fmt_mem[rd_ptr] : FMT_NONE;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed scenarios plus random
// traffic, compared against a queue-based reference of instruction words.
module tb_imm_decode_stage;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   ins = 32'h0;

    logic            in_ready, out_valid;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [CW-1:0]   count;

    logic            lg_in_ready, lg_out_valid;
    logic [XLEN-1:0] lg_imm;
    logic [2:0]      lg_fmt;
    logic [CW-1:0]   lg_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] mq[$];

    imm_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .LEGACY_ZEXT(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ins(ins), .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .fmt(fmt), .count(count)
    );

    imm_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .LEGACY_ZEXT(1)) dut_legacy (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(lg_in_ready),
        .ins(ins), .out_valid(lg_out_valid), .out_ready(out_ready), .imm(lg_imm), .fmt(lg_fmt), .count(lg_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int ref_fmt(input logic [31:0] w);
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: return 1;
            7'b0100011: return 2;
            7'b1100011: return 3;
            7'b0110111, 7'b0010111: return 4;
            7'b1101111: return 5;
            default: return 0;
        endcase
    endfunction

    // Immediate value as a plain integer, sign applied by subtracting 2^width.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input bit legacy);
        longint v;
        v = 0;
        case (ref_fmt(w))
            1: begin
                v = longint'(w[31:20]);
                if (!legacy && v >= 2048) v -= 4096;
            end
            2: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (!legacy && v >= 2048) v -= 4096;
            end
            3: begin
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (legacy) v = v / 2;
                else if (v >= 4096) v -= 8192;
            end
            4: begin
                v = longint'(w[31:12]) * 4096;
                if (w[31]) v -= 64'sh1_0000_0000;
            end
            5: begin
                v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] w, input bit r, input bit f);
        in_valid  = v;
        ins       = w;
        out_ready = r;
        flush     = f;
    endtask

    // Advance one clock and update the reference queue with the handshakes seen at that edge.
    task automatic tick();
        bit do_push, do_pop, do_flush;
        logic [31:0] w;
        do_push  = in_valid && (mq.size() < DEPTH);
        do_pop   = out_ready && (mq.size() > 0);
        do_flush = flush;
        w        = ins;
        @(posedge clk);
        #1;
        if (do_flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(w);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [63:0] e_imm, e_lg;
        int e_fmt;
        e_imm = 64'h0;
        e_lg  = 64'h0;
        e_fmt = 0;
        if (mq.size() > 0) begin
            e_imm = ref_imm(mq[0], 1'b0);
            e_lg  = ref_imm(mq[0], 1'b1);
            e_fmt = ref_fmt(mq[0]);
        end
        chk({tag, ".count"},     64'(count),     64'(mq.size()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() != DEPTH));
        chk({tag, ".fmt"},       64'(fmt),       64'(e_fmt));
        chk({tag, ".imm"},       imm,            e_imm);
        chk({tag, ".lg_imm"},    lg_imm,         e_lg);
        chk({tag, ".lg_fmt"},    64'(lg_fmt),    64'(e_fmt));
        chk({tag, ".lg_count"},  64'(lg_count),  64'(mq.size()));
    endtask

    logic [6:0] ops [10] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

    initial begin
        logic [31:0] r;

        #3;
        checkOutput("reset");
        rst_n = 1'b1;
        tick();
        checkOutput("idle");

        // addi -1, then stream the remaining directed words with consumer ready
        applyStimulus(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        tick();
        checkOutput("addi");
        chk("addi.const_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi.const_fmt", 64'(fmt), 64'd1);

        applyStimulus(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        tick();
        checkOutput("beq");
        chk("beq.const_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq.const_lg_imm", lg_imm, 64'h0000_0000_0000_0FFE);
        chk("beq.const_fmt", 64'(fmt), 64'd3);

        applyStimulus(1'b1, 32'h123450B7, 1'b1, 1'b0);
        tick();
        checkOutput("lui");
        chk("lui.const_imm", imm, 64'h0000_0000_1234_5000);
        chk("lui.const_fmt", 64'(fmt), 64'd4);

        applyStimulus(1'b1, 32'h0000006F, 1'b1, 1'b0);
        tick();
        checkOutput("jal");
        chk("jal.const_fmt", 64'(fmt), 64'd5);

        applyStimulus(1'b1, 32'h00000033, 1'b1, 1'b0);
        tick();
        checkOutput("rtype");
        chk("rtype.const_fmt", 64'(fmt), 64'd0);
        chk("rtype.const_valid", 64'(out_valid), 64'd1);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain0");

        // Fill to DEPTH with the consumer stalled; the third offer must be held off
        applyStimulus(1'b1, 32'h00100093, 1'b0, 1'b0);
        tick();
        checkOutput("fill1");
        applyStimulus(1'b1, 32'hFE112E23, 1'b0, 1'b0);
        tick();
        checkOutput("fill2");
        chk("full.const_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 32'h800000B7, 1'b0, 1'b0);
        tick();
        checkOutput("held");
        chk("full.const_count", 64'(count), 64'd2);
        applyStimulus(1'b1, 32'h800000B7, 1'b1, 1'b0);
        tick();
        checkOutput("full_pop_no_push");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain1");
        tick();
        checkOutput("drain2");
        tick();
        checkOutput("pop_empty");

        // Full buffer with push, pop and flush together
        applyStimulus(1'b1, 32'h00500113, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00600193, 1'b0, 1'b0);
        tick();
        checkOutput("prefill");
        applyStimulus(1'b1, 32'h7FF00213, 1'b1, 1'b1);
        tick();
        checkOutput("flush");
        chk("flush.const_count", 64'(count), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("after_flush");

        // Asynchronous reset between edges while one entry is held
        applyStimulus(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        tick();
        checkOutput("pre_reset");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        checkOutput("async_reset");
        chk("async_reset.const_imm", imm, 64'h0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h0000006F, 1'b0, 1'b0);
        tick();
        checkOutput("post_reset_push");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            applyStimulus(($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 9)]},
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
            tick();
            checkOutput("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
